// File: rtl/sram_group_packer_if.sv
// Stream-in handshake and SRAM write port of the column-score group packer.
interface sram_group_packer_if #(
  parameter int DATA_WIDTH = 18,
  parameter int WORD_WIDTH = 256,
  parameter int ADDR_WIDTH = 10
);
  logic                  i_start;
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_v;
  logic [DATA_WIDTH-1:0] i_f;
  logic                  i_last;
  logic                  o_ready;
  logic                  o_cen;
  logic                  o_wen;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [WORD_WIDTH-1:0] o_data;
  logic [ADDR_WIDTH:0]   o_word_cnt;
  logic                  o_done;
  logic                  o_overflow;

  modport master (
    output i_start, i_valid, i_v, i_f, i_last,
    input  o_ready, o_cen, o_wen, o_addr, o_data, o_word_cnt, o_done, o_overflow
  );

  modport slave (
    input  i_start, i_valid, i_v, i_f, i_last,
    output o_ready, o_cen, o_wen, o_addr, o_data, o_word_cnt, o_done, o_overflow
  );
endinterface

// File: rtl/sram_group_packer.sv
// Packs (V,F) score pairs GROUPS per SRAM word with a {last, count} header and
// writes the words sequentially into the T-buffer SRAM from address 0.
module sram_group_packer #(
  parameter int DATA_WIDTH = 18,
  parameter int GROUPS     = 7,
  parameter int WORD_WIDTH = 256,
  parameter int HEADER_BIT = 4,
  parameter int ADDR_WIDTH = 10
) (
  input logic               clk,
  input logic               rst,
  sram_group_packer_if.slave bus
);
  localparam int PAIR_W = 2 * DATA_WIDTH;
  localparam int PACK_W = GROUPS * PAIR_W;
  localparam int CNT_W  = HEADER_BIT - 1;

  localparam logic [CNT_W-1:0]    LAST_G   = CNT_W'(GROUPS - 1);
  localparam logic [CNT_W-1:0]    ONE_G    = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        gcnt;
  logic [PACK_W-1:0]       pack;
  logic [PACK_W-1:0]       pack_next;
  logic                    last_word;
  logic                    accept;
  logic                    word_full;
  logic [WORD_WIDTH-1:0]   word_next;

  logic                    ready;
  logic                    cen;
  logic                    wen;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [WORD_WIDTH-1:0]   data;
  logic [ADDR_WIDTH:0]     word_cnt;
  logic                    done;
  logic                    overflow;

  assign accept = (state == FILL) && ready && bus.i_valid;

  // The completing pair is merged combinationally so the full word can be
  // registered onto the SRAM bus on the same edge that accepts it.
  always_comb begin
    pack_next = pack;
    pack_next[gcnt * PAIR_W +: PAIR_W] = {bus.i_v, bus.i_f};
    word_full = (gcnt == LAST_G) || bus.i_last;
    word_next = '0;
    word_next[PACK_W-1:0] = pack_next;
    word_next[WORD_WIDTH-1 -: HEADER_BIT] = {bus.i_last, gcnt + ONE_G};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gcnt      <= '0;
      pack      <= '0;
      last_word <= 1'b0;
      ready     <= 1'b0;
      cen       <= 1'b1;
      wen       <= 1'b1;
      addr      <= '0;
      data      <= '0;
      word_cnt  <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.i_start) begin
            state    <= FILL;
            gcnt     <= '0;
            pack     <= '0;
            addr     <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
            ready    <= 1'b1;
          end
        end
        FILL: begin
          if (accept) begin
            if (word_full) begin
              state     <= WRITE;
              ready     <= 1'b0;
              cen       <= 1'b0;
              wen       <= 1'b0;
              data      <= word_next;
              last_word <= bus.i_last;
              word_cnt  <= word_cnt + CNT_ONE;
              pack      <= '0;
              gcnt      <= '0;
            end else begin
              pack <= pack_next;
              gcnt <= gcnt + ONE_G;
            end
          end
        end
        WRITE: begin
          cen <= 1'b1;
          wen <= 1'b1;
          if (last_word) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (addr == '1) begin
            overflow <= 1'b1;
            state    <= DONE;
            done     <= 1'b1;
          end else begin
            addr  <= addr + ADDR_ONE;
            state <= FILL;
            ready <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_cen      = cen;
  assign bus.o_wen      = wen;
  assign bus.o_addr     = addr;
  assign bus.o_data     = data;
  assign bus.o_word_cnt = word_cnt;
  assign bus.o_done     = done;
  assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_sram_group_packer.sv
// Self-checking bench for sram_group_packer: stream-level model plus directed tests.
module tb_sram_group_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_group_packer_if #(.DATA_WIDTH(18), .WORD_WIDTH(256), .ADDR_WIDTH(10)) bus ();

  sram_group_packer #(
    .DATA_WIDTH(18), .GROUPS(7), .WORD_WIDTH(256), .HEADER_BIT(4), .ADDR_WIDTH(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [17:0] v;
    logic [17:0] f;
    logic        l;
  } pair_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream model: accepted pairs in order, the word they must form, and when.
  pair_t        q[$];
  logic [255:0] mem [0:1023];
  logic [255:0] data_m = '0;
  int           grp = 0;
  int           wr_idx = 0;
  bit           wr_now = 0, done_now = 0, idle_m = 1, ovf_m = 0;
  int           last_wr_addr = -1;

  logic [255:0] w;
  int           n;
  logic         lf;
  pair_t        p;
  bit           new_wr, new_done;

  always @(negedge clk) begin
    chk("cen", 256'(bus.o_cen), 256'(!wr_now));
    chk("wen", 256'(bus.o_wen), 256'(!wr_now));
    chk("ready", 256'(bus.o_ready), 256'(!(idle_m || wr_now || done_now)));
    chk("done", 256'(bus.o_done), 256'(done_now));
    chk("overflow", 256'(bus.o_overflow), 256'(ovf_m));
    chk("word_cnt", 256'(bus.o_word_cnt), 256'(wr_now ? wr_idx + 1 : wr_idx));
    if (done_now) chk("done_all_written", 256'(q.size()), 256'(0));
    new_done = 0;
    if (wr_now) begin
      w = '0; n = 0; lf = 0;
      while (n < 7 && q.size() > 0 && !lf) begin
        p = q.pop_front();
        w[n*36 +: 36] = {p.v, p.f};
        lf = p.l;
        n++;
      end
      w[255:252] = {lf, 3'(n)};
      chk("addr", 256'(bus.o_addr), 256'(wr_idx));
      chk("data", bus.o_data, w);
      mem[bus.o_addr] = bus.o_data;
      last_wr_addr = int'(bus.o_addr);
      data_m = w;
      new_done = lf || (wr_idx == 1023);
      if (!lf && wr_idx == 1023) ovf_m = 1;
      wr_idx++;
    end else begin
      chk("data_hold", bus.o_data, data_m);
    end

    if (rst) begin
      q.delete();
      grp = 0; wr_idx = 0; data_m = '0;
      wr_now = 0; done_now = 0; idle_m = 1; ovf_m = 0;
    end else begin
      new_wr = 0;
      if (bus.i_valid && bus.o_ready) begin
        q.push_back('{v: bus.i_v, f: bus.i_f, l: bus.i_last});
        if (grp == 6 || bus.i_last) begin
          new_wr = 1; grp = 0;
        end else grp++;
      end
      if (done_now) idle_m = 1;
      else if (idle_m && bus.i_start) begin
        idle_m = 0; ovf_m = 0; wr_idx = 0; grp = 0;
      end
      wr_now = new_wr;
      done_now = new_done;
    end
  end

  task automatic start_stream();
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic send(input logic [17:0] v, input logic [17:0] f, input logic l);
    int unsigned t = 0;
    bus.i_valid = 1'b1; bus.i_v = v; bus.i_f = f; bus.i_last = l;
    forever begin
      @(negedge clk);
      if (bus.o_ready) break;
      t++;
      if (t > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: got ready=0 for 50 cycles expected ready=1");
        break;
      end
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_last = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_done) begin seen = 1; break; end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no o_done in 20 cycles expected pulse");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  logic [255:0] word;
  int unsigned  cyc, idx;
  logic         rdy [0:40];

  initial begin
    bus.i_start = 0; bus.i_valid = 0; bus.i_v = '0; bus.i_f = '0; bus.i_last = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 256'(bus.o_ready), 256'(0));
    chk("rst_cen", 256'(bus.o_cen), 256'(1));
    chk("rst_data", bus.o_data, 256'(0));

    // 1: exactly one full word that is also the last
    start_stream();
    for (int k = 0; k < 7; k++) send(18'(k + 1), 18'(100 + k), k == 6);
    wait_done();
    word = mem[0];
    chk("t1_hdr", 256'(word[255:252]), 256'(4'b1111));
    chk("t1_g0", 256'(word[35:0]), 256'({18'd1, 18'd100}));
    chk("t1_g6", 256'(word[251:216]), 256'({18'd7, 18'd106}));
    chk("t1_cnt", 256'(bus.o_word_cnt), 256'(1));

    // 2: 10 pairs -> full word + 3-group last word; a start mid-stream is ignored
    start_stream();
    for (int k = 0; k < 10; k++) begin
      if (k == 3) bus.i_start = 1'b1;
      send(18'(k + 1), 18'(50 + k), k == 9);
      bus.i_start = 1'b0;
    end
    wait_done();
    word = mem[0];
    chk("t2_hdr0", 256'(word[255:252]), 256'(4'b0111));
    word = mem[1];
    chk("t2_hdr1", 256'(word[255:252]), 256'(4'b1011));
    chk("t2_zero", 256'(word[251:108]), 256'(0));
    chk("t2_cnt", 256'(bus.o_word_cnt), 256'(2));

    // 3: single pair with sign bit set
    start_stream();
    send(18'h20000, 18'd5, 1'b1);
    wait_done();
    word = mem[0];
    chk("t3_hdr", 256'(word[255:252]), 256'(4'b1001));
    chk("t3_g0", 256'(word[35:0]), 256'({18'h20000, 18'd5}));
    chk("t3_rest", 256'(word[251:36]), 256'(0));

    // 4: continuous valid, 14 pairs: one bubble after the 7th and 14th accept
    start_stream();
    cyc = 0; idx = 0;
    bus.i_valid = 1'b1;
    while (idx < 14 && cyc < 40) begin
      bus.i_v = 18'(200 + idx); bus.i_f = 18'(300 + idx);
      @(negedge clk);
      rdy[cyc] = bus.o_ready;
      if (bus.o_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_valid = 1'b0;
    chk("t4_cycles", 256'(cyc), 256'(15));
    chk("t4_gap7", 256'(rdy[7]), 256'(0));
    chk("t4_run", 256'(rdy[6] & rdy[8] & rdy[14]), 256'(1));
    @(negedge clk);
    chk("t4_gap14", 256'(bus.o_ready), 256'(0));
    @(negedge clk);
    chk("t4_resume", 256'(bus.o_ready), 256'(1));
    @(posedge clk); #1;
    send(18'd999, 18'd888, 1'b1);
    wait_done();
    chk("t4_cnt", 256'(bus.o_word_cnt), 256'(3));

    // 5: 7*1024+1 pairs, no last: capacity overflow
    start_stream();
    for (int k = 0; k < 7168; k++) send(18'(k), 18'(k * 3), 1'b0);
    bus.i_valid = 1'b1; bus.i_v = 18'h3ffff; bus.i_f = 18'h3ffff;
    wait_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_held", 256'(bus.o_ready), 256'(0));
    end
    bus.i_valid = 1'b0;
    chk("t5_ovf", 256'(bus.o_overflow), 256'(1));
    chk("t5_cnt", 256'(bus.o_word_cnt), 256'(1024));
    chk("t5_lastaddr", 256'(last_wr_addr), 256'(1023));
    start_stream();
    @(negedge clk);
    chk("t5_ovf_clr", 256'(bus.o_overflow), 256'(0));
    @(posedge clk); #1;
    send(18'd1, 18'd2, 1'b1);
    wait_done();
    word = mem[0];
    chk("t5_after", 256'(word[255:252]), 256'(4'b1001));

    // 6: reset mid-fill discards the partial word
    start_stream();
    for (int k = 0; k < 3; k++) send(18'(40 + k), 18'(60 + k), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready", 256'(bus.o_ready), 256'(0));
    chk("t6_cen", 256'(bus.o_cen), 256'(1));
    chk("t6_wen", 256'(bus.o_wen), 256'(1));
    chk("t6_addr", 256'(bus.o_addr), 256'(0));
    chk("t6_data", bus.o_data, 256'(0));
    chk("t6_cnt", 256'(bus.o_word_cnt), 256'(0));
    chk("t6_done", 256'(bus.o_done), 256'(0));
    chk("t6_ovf", 256'(bus.o_overflow), 256'(0));
    start_stream();
    send(18'd9, 18'd8, 1'b0);
    send(18'd7, 18'd6, 1'b1);
    wait_done();
    word = mem[0];
    chk("t6_addr0", 256'(last_wr_addr), 256'(0));
    chk("t6_hdr", 256'(word[255:252]), 256'(4'b1010));
    chk("t6_g1", 256'(word[71:36]), 256'({18'd7, 18'd6}));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
